// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg
// Shared types and default widths for the two-requester RAM bank arbiter.
//   ctrl_state_t : sequencer states (IDLE, CMD, CAP, RESP)
//   req_id_t     : requester index (0 or 1)
//   ram_cmd_t    : request fields latched at grant time
package ram_ctrl_pkg;

  localparam int DATA_W = 4;
  localparam int ROW_W  = 2;
  localparam int COL_W  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    CAP  = 2'd2,
    RESP = 2'd3
  } ctrl_state_t;

  typedef logic req_id_t;

  typedef struct packed {
    logic              wr;
    logic              bank;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    logic [DATA_W-1:0] wdata;
  } ram_cmd_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2
// Two-way round-robin arbiter. On a tie the requester not served last wins.
// The last-served pointer resets to 1 (so requester 0 wins the first tie)
// and only moves when grant_i confirms the winner was taken.
// Ports:
//   clk_i, rst_i     clock, async active-high reset
//   req0_i, req1_i   request lines
//   grant_i          winner accepted this cycle; update pointer
//   valid_o          at least one request present
//   win_o            winning requester id
module rr_arbiter2
  import ram_ctrl_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic req0_i,
  input  logic req1_i,
  input  logic grant_i,
  output logic valid_o,
  output logic win_o
);

  req_id_t last_q, last_d;

  always_comb begin
    valid_o = req0_i | req1_i;
    if (req0_i && req1_i) begin
      win_o = ~last_q;
    end else begin
      win_o = req1_i;
    end
    last_d = last_q;
    if (grant_i && valid_o) begin
      last_d = win_o;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/ram_bank_arbiter.sv
// ram_bank_arbiter
// Arbitrates two masters onto one two-bank basic_ram and sequences a single
// access cycle per transaction. All outputs are registered.
// Ports:
//   clk_i, rst_i                       clock, async active-high reset
//   reqN_i, wrN_i, bankN_i, rowN_i,
//   colN_i, wdataN_i                   requester N command (N = 0, 1)
//   gntN_o, doneN_o                    one-cycle grant / completion pulses
//   rdataN_o                           read data, held until next read
//   ram_cs_o, ram_we_o, ram_oe_o       RAM controls, high only in CMD
//   ram_bank_o, ram_row_o, ram_col_o,
//   ram_din_o                          RAM address/data, hold last value
//   ram_dout_i                         RAM read data (registered by RAM)
//
// state | meaning
// IDLE  | arbitrate; latch winner's command
// CMD   | gnt pulse, RAM pins active for one access edge
// CAP   | reads only: capture ram_dout into winner's rdata
// RESP  | done pulse to winner
module ram_bank_arbiter #(
  parameter int DATA_W = ram_ctrl_pkg::DATA_W,
  parameter int ROW_W  = ram_ctrl_pkg::ROW_W,
  parameter int COL_W  = ram_ctrl_pkg::COL_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_i,
  input  logic              wr0_i,
  input  logic              bank0_i,
  input  logic [ROW_W-1:0]  row0_i,
  input  logic [COL_W-1:0]  col0_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic              req1_i,
  input  logic              wr1_i,
  input  logic              bank1_i,
  input  logic [ROW_W-1:0]  row1_i,
  input  logic [COL_W-1:0]  col1_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic              gnt0_o,
  output logic              gnt1_o,
  output logic              done0_o,
  output logic              done1_o,
  output logic [DATA_W-1:0] rdata0_o,
  output logic [DATA_W-1:0] rdata1_o,
  output logic              ram_cs_o,
  output logic              ram_we_o,
  output logic              ram_oe_o,
  output logic [1:0]        ram_bank_o,
  output logic [ROW_W-1:0]  ram_row_o,
  output logic [COL_W-1:0]  ram_col_o,
  output logic [DATA_W-1:0] ram_din_o,
  input  logic [DATA_W-1:0] ram_dout_i
);

  import ram_ctrl_pkg::*;

  ctrl_state_t       state_q, state_d;
  ram_cmd_t          cmd_q, cmd_d;
  req_id_t           id_q, id_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        done_q, done_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              cs_q, cs_d;
  logic              we_q, we_d;
  logic              oe_q, oe_d;

  logic     arb_valid;
  logic     arb_win;
  logic     arb_grant;
  ram_cmd_t sel_cmd;

  rr_arbiter2 u_arb (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req0_i  (req0_i),
    .req1_i  (req1_i),
    .grant_i (arb_grant),
    .valid_o (arb_valid),
    .win_o   (arb_win)
  );

  always_comb begin
    if (arb_win) begin
      sel_cmd = '{wr: wr1_i, bank: bank1_i, row: row1_i, col: col1_i, wdata: wdata1_i};
    end else begin
      sel_cmd = '{wr: wr0_i, bank: bank0_i, row: row0_i, col: col0_i, wdata: wdata0_i};
    end
  end

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    id_d      = id_q;
    gnt_d     = 2'b00;
    done_d    = 2'b00;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    cs_d      = 1'b0;
    we_d      = 1'b0;
    oe_d      = 1'b0;
    arb_grant = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          arb_grant    = 1'b1;
          id_d         = arb_win;
          cmd_d.wr     = sel_cmd.wr;
          cmd_d.bank   = sel_cmd.bank;
          cmd_d.row    = sel_cmd.row;
          cmd_d.col    = sel_cmd.col;
          // ram_din is driven straight from cmd_q, so reads keep the last write data
          if (sel_cmd.wr) begin
            cmd_d.wdata = sel_cmd.wdata;
          end
          gnt_d[arb_win] = 1'b1;
          cs_d         = 1'b1;
          we_d         = sel_cmd.wr;
          oe_d         = ~sel_cmd.wr;
          state_d      = CMD;
        end
      end
      CMD: begin
        if (cmd_q.wr) begin
          done_d[id_q] = 1'b1;
          state_d      = RESP;
        end else begin
          state_d = CAP;
        end
      end
      CAP: begin
        if (id_q) begin
          rdata1_d = ram_dout_i;
        end else begin
          rdata0_d = ram_dout_i;
        end
        done_d[id_q] = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cmd_q    <= '0;
      id_q     <= 1'b0;
      gnt_q    <= 2'b00;
      done_q   <= 2'b00;
      rdata0_q <= '0;
      rdata1_q <= '0;
      cs_q     <= 1'b0;
      we_q     <= 1'b0;
      oe_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      id_q     <= id_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      cs_q     <= cs_d;
      we_q     <= we_d;
      oe_q     <= oe_d;
    end
  end

  assign gnt0_o     = gnt_q[0];
  assign gnt1_o     = gnt_q[1];
  assign done0_o    = done_q[0];
  assign done1_o    = done_q[1];
  assign rdata0_o   = rdata0_q;
  assign rdata1_o   = rdata1_q;
  assign ram_cs_o   = cs_q;
  assign ram_we_o   = we_q;
  assign ram_oe_o   = oe_q;
  assign ram_bank_o = {1'b0, cmd_q.bank};
  assign ram_row_o  = cmd_q.row;
  assign ram_col_o  = cmd_q.col;
  assign ram_din_o  = cmd_q.wdata;

endmodule

// File: tb/tb_ram_bank_arbiter.sv
// tb_ram_bank_arbiter
// Directed bench for ram_bank_arbiter with a behavioural RAM, a
// transaction-level reference model compared every cycle, and directed
// literal expectations for latency, data, ordering and reset behaviour.
module tb_ram_bank_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0, wr0, bank0, req1, wr1, bank1;
  logic [1:0] row0, col0, row1, col1;
  logic [3:0] wdata0, wdata1;
  logic       gnt0, gnt1, done0, done1;
  logic [3:0] rdata0, rdata1;
  logic       ram_cs, ram_we, ram_oe;
  logic [1:0] ram_bank, ram_row, ram_col;
  logic [3:0] ram_din;
  logic [3:0] ram_dout = 4'h0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_bank_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .req0_i(req0), .wr0_i(wr0), .bank0_i(bank0), .row0_i(row0), .col0_i(col0), .wdata0_i(wdata0),
    .req1_i(req1), .wr1_i(wr1), .bank1_i(bank1), .row1_i(row1), .col1_i(col1), .wdata1_i(wdata1),
    .gnt0_o(gnt0), .gnt1_o(gnt1), .done0_o(done0), .done1_o(done1),
    .rdata0_o(rdata0), .rdata1_o(rdata1),
    .ram_cs_o(ram_cs), .ram_we_o(ram_we), .ram_oe_o(ram_oe),
    .ram_bank_o(ram_bank), .ram_row_o(ram_row), .ram_col_o(ram_col),
    .ram_din_o(ram_din), .ram_dout_i(ram_dout)
  );

  // Behavioural basic_ram: synchronous write, registered read.
  logic [3:0] ram_mem [32] = '{default: 4'h0};
  always @(posedge clk) begin
    if (ram_cs && ram_we) ram_mem[{ram_bank[0], ram_row, ram_col}] <= ram_din;
    if (ram_cs && ram_oe) ram_dout <= ram_mem[{ram_bank[0], ram_row, ram_col}];
  end

  // Reference model: a transaction occupies phases 1..N after its sampling
  // edge (N = 2 write, 3 read); phase 1 is the pin cycle, phase N the done cycle.
  int m_busy = 0, m_phase = 0, m_id = 0, m_last = 1, m_wr = 0, m_addr = 0;
  int e_bank = 0, e_row = 0, e_col = 0, e_din = 0;
  int e_rdata [2] = '{0, 0};
  int mem_m [32] = '{default: 0};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_phase = 0; m_id = 0; m_last = 1; m_wr = 0; m_addr = 0;
      e_bank = 0; e_row = 0; e_col = 0; e_din = 0;
      e_rdata[0] = 0; e_rdata[1] = 0;
    end else if (m_busy == 0) begin
      if (req0 || req1) begin
        if (req0 && req1) m_id = 1 - m_last;
        else m_id = req1 ? 1 : 0;
        m_last = m_id; m_busy = 1; m_phase = 1;
        if (m_id == 0) begin
          m_wr = int'(wr0); e_bank = int'(bank0); e_row = int'(row0); e_col = int'(col0);
        end else begin
          m_wr = int'(wr1); e_bank = int'(bank1); e_row = int'(row1); e_col = int'(col1);
        end
        m_addr = e_bank * 16 + e_row * 4 + e_col;
        if (m_wr == 1) begin
          e_din = (m_id == 0) ? int'(wdata0) : int'(wdata1);
          mem_m[m_addr] = e_din;
        end
      end
    end else begin
      m_phase = m_phase + 1;
      if (m_wr == 0 && m_phase == 3) e_rdata[m_id] = mem_m[m_addr];
      if (m_phase == ((m_wr == 1) ? 3 : 4)) m_busy = 0;
    end
  end

  // Monitor state, written only by the compare process.
  int gq[$];
  int cnt_gnt0 = 0, cnt_done0 = 0, cnt_cs = 0, cnt_we = 0, cnt_both = 0;
  int bank_at_gnt1 = -1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d time=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic wait_done(input int id, output int ncyc);
    int seen;
    seen = 0;
    ncyc = 0;
    while (seen == 0 && ncyc < 30) begin
      @(posedge clk);
      ncyc++;
      @(negedge clk);
      if ((id == 0 && done0) || (id == 1 && done1)) seen = 1;
    end
    chk((id == 0) ? "done0_seen" : "done1_seen", seen, 1);
    @(posedge clk);
    #1;
    if (id == 0) req0 = 1'b0;
    else req1 = 1'b0;
  endtask

  task automatic set0(input logic w, input logic b, input logic [1:0] r, input logic [1:0] c, input logic [3:0] d);
    wr0 = w; bank0 = b; row0 = r; col0 = c; wdata0 = d;
  endtask

  task automatic set1(input logic w, input logic b, input logic [1:0] r, input logic [1:0] c, input logic [3:0] d);
    wr1 = w; bank1 = b; row1 = r; col1 = c; wdata1 = d;
  endtask

  initial begin
    int n, na, nb, g0, c0, d0, b0, k;
    rst = 1'b1;
    set0(1'b0, 1'b0, 2'd0, 2'd0, 4'h0);
    set1(1'b0, 1'b0, 2'd1, 2'd1, 4'h0);
    req0 = 1'b1;
    req1 = 1'b1;

    fork
      forever begin
        @(negedge clk);
        if (!rst) begin
          chk("gnt0",  int'(gnt0),  int'(m_busy == 1 && m_phase == 1 && m_id == 0));
          chk("gnt1",  int'(gnt1),  int'(m_busy == 1 && m_phase == 1 && m_id == 1));
          chk("done0", int'(done0), int'(m_busy == 1 && m_phase == ((m_wr == 1) ? 2 : 3) && m_id == 0));
          chk("done1", int'(done1), int'(m_busy == 1 && m_phase == ((m_wr == 1) ? 2 : 3) && m_id == 1));
          chk("rdata0", int'(rdata0), e_rdata[0]);
          chk("rdata1", int'(rdata1), e_rdata[1]);
          chk("ram_cs", int'(ram_cs), int'(m_busy == 1 && m_phase == 1));
          chk("ram_we", int'(ram_we), int'(m_busy == 1 && m_phase == 1 && m_wr == 1));
          chk("ram_oe", int'(ram_oe), int'(m_busy == 1 && m_phase == 1 && m_wr == 0));
          chk("ram_bank", int'(ram_bank), e_bank);
          chk("ram_row", int'(ram_row), e_row);
          chk("ram_col", int'(ram_col), e_col);
          chk("ram_din", int'(ram_din), e_din);
        end
        if (gnt0) begin gq.push_back(0); cnt_gnt0++; end
        if (gnt1) begin gq.push_back(1); bank_at_gnt1 = int'(ram_bank); end
        if (done0) cnt_done0++;
        if (ram_cs) cnt_cs++;
        if (ram_we) cnt_we++;
        if (gnt0 && gnt1) cnt_both++;
      end
    join_none

    // Reset with both requests pending: requester 0 first, then 1.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    fork
      wait_done(0, na);
      wait_done(1, nb);
    join
    chk("t1_grant_count", gq.size(), 2);
    chk("t1_first_grant", gq[0], 0);
    chk("t1_second_grant", gq[1], 1);

    // Write then read back the same word from requester 0.
    c0 = cnt_we;
    set0(1'b1, 1'b0, 2'd1, 2'd2, 4'hA);
    req0 = 1'b1;
    wait_done(0, n);
    chk("t2_write_latency", n, 2);
    chk("t2_we_cycles", cnt_we - c0, 1);
    set0(1'b0, 1'b0, 2'd1, 2'd2, 4'h0);
    req0 = 1'b1;
    wait_done(0, n);
    chk("t2_read_latency", n, 3);
    chk("t2_rdata0", int'(rdata0), 10);

    // Same row/col in different banks must not alias.
    set1(1'b1, 1'b1, 2'd3, 2'd3, 4'h5);
    set0(1'b0, 1'b0, 2'd3, 2'd3, 4'h0);
    req0 = 1'b1;
    req1 = 1'b1;
    fork
      wait_done(1, na);
      wait_done(0, nb);
    join
    chk("t3_bank_during_gnt1", bank_at_gnt1, 1);
    chk("t3_rdata0_other_bank", int'(rdata0), 0);

    // Continuous contention after reset: strict alternation starting at 0.
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    g0 = gq.size();
    b0 = cnt_both;
    set0(1'b1, 1'b0, 2'd0, 2'd0, 4'h3);
    set1(1'b0, 1'b0, 2'd1, 2'd2, 4'h0);
    req0 = 1'b1;
    req1 = 1'b1;
    n = 0;
    while (gq.size() < g0 + 6 && n < 100) begin
      @(negedge clk);
      n++;
    end
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("t4_grant_total", gq.size() - g0, 6);
    for (int i = 0; i < 6; i++) chk("t4_grant_order", gq[g0 + i], i % 2);
    chk("t4_both_gnt_cycles", cnt_both - b0, 0);
    chk("t4_rdata1", int'(rdata1), 10);

    // Reset during a read's CAP cycle.
    d0 = cnt_done0;
    set0(1'b0, 1'b0, 2'd1, 2'd2, 4'h0);
    req0 = 1'b1;
    k = 0;
    while (!gnt0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("t5_gnt0_seen", int'(gnt0), 1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("t5_rst_gnt0", int'(gnt0), 0);
    chk("t5_rst_gnt1", int'(gnt1), 0);
    chk("t5_rst_done0", int'(done0), 0);
    chk("t5_rst_done1", int'(done1), 0);
    chk("t5_rst_rdata0", int'(rdata0), 0);
    chk("t5_rst_rdata1", int'(rdata1), 0);
    chk("t5_rst_cs", int'(ram_cs), 0);
    chk("t5_rst_we", int'(ram_we), 0);
    chk("t5_rst_oe", int'(ram_oe), 0);
    chk("t5_rst_bank", int'(ram_bank), 0);
    chk("t5_rst_row", int'(ram_row), 0);
    chk("t5_rst_col", int'(ram_col), 0);
    chk("t5_rst_din", int'(ram_din), 0);
    set1(1'b0, 1'b0, 2'd0, 2'd0, 4'h0);
    req1 = 1'b1;
    repeat (2) @(posedge clk);
    chk("t5_no_done_after_abort", cnt_done0 - d0, 0);
    g0 = gq.size();
    @(negedge clk);
    rst = 1'b0;
    fork
      wait_done(0, na);
      wait_done(1, nb);
    join
    chk("t5_first_grant_after_rst", gq[g0], 0);
    chk("t5_done0_count", cnt_done0 - d0, 1);

    // Short req0 pulse during requester 1's CMD is never served.
    c0 = cnt_cs;
    d0 = cnt_gnt0;
    set1(1'b1, 1'b1, 2'd0, 2'd1, 4'h7);
    req1 = 1'b1;
    fork
      wait_done(1, n);
      begin
        k = 0;
        while (!gnt1 && k < 20) begin
          @(negedge clk);
          k++;
        end
        chk("t6_gnt1_seen", int'(gnt1), 1);
        set0(1'b0, 1'b1, 2'd0, 2'd1, 4'h0);
        req0 = 1'b1;
        @(negedge clk);
        req0 = 1'b0;
      end
    join
    repeat (4) @(posedge clk);
    #1;
    chk("t6_gnt0_count", cnt_gnt0 - d0, 0);
    chk("t6_cs_cycles", cnt_cs - c0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_bank_arbiter.md
# ram_bank_arbiter

Two-requester arbiter and sequencer for the two-bank 4x4 x 4-bit `basic_ram` array. It accepts independent read/write requests from two masters and grants them round-robin. It drives the RAM's chip-select, write/output-enable, bank, row, column and data pins for exactly one access cycle, then returns read data and a completion pulse to the winner. It sits between the requesting logic and the RAM instance, and is the only block that drives the RAM control pins.

## Interface
Parameters:
- `DATA_W`, 4, data width of RAM word and requester data
- `ROW_W`, 2, row address width
- `COL_W`, 2, column address width

Ports (x = 0, 1 for each requester):
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `reqx`  in  1  request; held high until `donex`
- `wrx`  in  1  1 = write, 0 = read
- `bankx`  in  1  bank select (0 = bank 1, 1 = bank 2)
- `rowx` / `colx`  in  ROW_W / COL_W  word address
- `wdatax`  in  DATA_W  write data
- `gntx`  out  1  one-cycle pulse: request accepted and fields latched
- `donex`  out  1  one-cycle pulse: access complete
- `rdatax`  out  DATA_W  read data, valid while `donex` is high and held until the next read completes for that requester
- `ram_cs`, `ram_we`, `ram_oe`  out  1  RAM controls
- `ram_bank`  out  2  RAM `bank_selector`; bit 1 is always 0
- `ram_row` / `ram_col`  out  ROW_W / COL_W  RAM address
- `ram_din`  out  DATA_W  RAM write data
- `ram_dout`  in  DATA_W  RAM read data, which the RAM registers on the access edge

## Operation
- FSM states: `IDLE`, `CMD`, `CAP`, `RESP`. All outputs are registered.
- `IDLE`, arbitration:
  - If any `reqx` is high, pick a winner and latch its wr/bank/row/col/wdata and requester id. Go to `CMD`.
  - One requester active: it wins.
  - Both active: the requester not served last wins.
  - Last-served pointer resets to 1, so requester 0 wins the first tie.
  - The pointer updates only on grant.
- `CMD` drives `gntx = 1` for the winner and `ram_cs = 1`.
  - Write: `ram_we = 1`, `ram_oe = 0`, `ram_din` = latched wdata. Next state is `RESP`.
  - Read: `ram_we = 0`, `ram_oe = 1`. Next state is `CAP`.
- `CAP` (reads only): all RAM controls are 0. Load `ram_dout` into the winner's `rdatax` on the edge ending `CAP`. Next state is `RESP`.
- `RESP`: `donex = 1` for the winner. Next state is `IDLE`. The loser's request stays pending and is picked up in `IDLE`.
- Outside `CMD`:
  - `ram_cs`, `ram_we`, `ram_oe` are 0.
  - `ram_bank`, `ram_row`, `ram_col`, `ram_din` hold their last values (0 after reset).
- Requests are ignored outside `IDLE`.
- A requester must drop `reqx` on the edge ending its `donex` cycle, or a new transaction is taken.
- A `reqx` dropped before grant is simply not served.

## Timing
- Reset values: state `IDLE`, pointer = 1, and every output = 0 (`gntx`, `donex`, `rdatax`, all `ram_*`).
- Reset mid-operation:
  - Any in-flight access is abandoned with no `donex`.
  - A write already on RAM pins is deasserted asynchronously.
  - Requester must re-issue.
- Edge E0: `reqx` is sampled in `IDLE`.
  - Write: `CMD` in cycle E0+1, `RESP` in cycle E0+2.
  - Read: `CMD` in E0+1, `CAP` in E0+2, `RESP` in E0+3.
- Latency from sampling edge to `donex`: 2 cycles for a write, 3 cycles for a read.
- Throughput: one write per 3 cycles, one read per 4 cycles (includes the `IDLE` bubble).
- `gntx` and `donex` are never high for both requesters in the same cycle.

## Structure
- Package `ram_ctrl_pkg` holds:
  - the state enum `ctrl_state_t` (`IDLE`, `CMD`, `CAP`, `RESP`)
  - the requester-id typedef
  - `DATA_W` / `ROW_W` / `COL_W` defaults
  - a struct `ram_cmd_t` {wr, bank, row, col, wdata} for the latched request
- Sub-module `rr_arbiter2`: 2-way round-robin grant with pointer, `rst`-cleared.
- FSM and datapath live in the top module.

## Test plan
- Reset with both requests high, release: `gnt0` pulse first; after `done0`, `gnt1`.
- Req0 write bank 0 row 1 col 2 data 4'hA, then req0 read the same address: `ram_we` high for exactly 1 cycle; `done0` 2 cycles after sampling; read `done0` 3 cycles after sampling with `rdata0 = 4'hA`.
- Req1 writes 4'h5 to bank 1 row 3 col 3, req0 reads bank 0 row 3 col 3: `rdata0` is not 4'h5, and `ram_bank` is `2'b01` during req1's `CMD`.
- Both requests held continuously for 6 transactions: grants alternate 0,1,0,1,0,1, with no cycle where both `gnt` are high.
- Assert `rst` during a read's `CAP`: all outputs 0 immediately, no `done`, and the next grant goes to requester 0.
- Req0 pulsed high for 1 cycle during requester 1's `CMD`: never granted, and no spurious RAM access.
